// File: rtl/frame_loader.sv
// -----------------------------------------------------------------------------
// frame_loader
//
// Receives a frame of bytes from a UART receiver, unpacks each byte LSB-first
// into PIX_BITS-wide words written to a frame RAM, launches the inference
// core once the frame is complete, and sends the core result back as one
// UART byte. A partial frame is abandoned (frame_err) on inter-byte silence
// or on a byte that arrives while the previous one is still being unpacked.
//
// Optional feature (macro FRAME_CHECKSUM_EN): a trailing checksum byte, the
// modulo-256 sum of the payload, follows the payload. It is not written to
// RAM. On a mismatch the core is skipped and 0xEE is transmitted instead.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   rx_rdy/rx_data one-cycle strobe with a received byte
//   ram_we/ram_addr/ram_wdata  frame RAM write port
//   core_start     one-cycle pulse launching inference
//   core_done/core_result      one-cycle strobe with the inference result
//   tx_start/tx_data           one-cycle request to the UART transmitter
//   tx_rdy         transmitter idle
//   busy           high whenever a frame or response is in progress
//   frame_err      one-cycle pulse on timeout, overrun or checksum failure
// -----------------------------------------------------------------------------
module frame_loader #(
  parameter int FRAME_BYTES = 98,
  parameter int PIX_BITS    = 1,
  parameter int ADDR_W      = 10,
  parameter int RESULT_W    = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_rdy,
  input  logic [7:0]          rx_data,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [PIX_BITS-1:0] ram_wdata,
  output logic                core_start,
  input  logic                core_done,
  input  logic [RESULT_W-1:0] core_result,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  input  logic                tx_rdy,
  output logic                busy,
  output logic                frame_err
);

  localparam int SLICES  = 8 / PIX_BITS;
  localparam int SLICE_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int CNT_W   = $clog2(FRAME_BYTES + 2);
  localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);

  if (!(PIX_BITS == 1 || PIX_BITS == 2 || PIX_BITS == 4 || PIX_BITS == 8)) begin : g_bad_pix
    $error("frame_loader: PIX_BITS must be 1, 2, 4 or 8");
  end
  if (FRAME_BYTES * SLICES > (1 << ADDR_W)) begin : g_bad_addr
    $error("frame_loader: frame does not fit in 2**ADDR_W words");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_RX_WAIT, S_UNPACK, S_CORE, S_TX, S_TX_WAIT
  } state_t;

  state_t              r_state;
  logic [7:0]          r_shift;      // bits of the current byte not yet written
  logic [SLICE_W-1:0]  r_slice;      // index of the slice currently on the RAM port
  logic [CNT_W-1:0]    r_byte_cnt;
  logic [TMO_W-1:0]    r_idle_cnt;
  logic [RESULT_W-1:0] r_result;
  logic                r_tx_first;   // first TX_WAIT cycle; tx_rdy has not dropped yet
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [PIX_BITS-1:0] r_ram_wdata;
  logic                r_core_start;
  logic                r_tx_start;
  logic [7:0]          r_tx_data;
  logic                r_busy;
  logic                r_frame_err;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]          r_sum;
  logic                r_cs_err;
`endif

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; blocking assignments would make the result
  // depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_slice      <= '0;
      r_byte_cnt   <= '0;
      r_idle_cnt   <= '0;
      r_result     <= '0;
      r_tx_first   <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_core_start <= 1'b0;
      r_tx_start   <= 1'b0;
      r_tx_data    <= '0;
      r_busy       <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      r_sum        <= '0;
      r_cs_err     <= 1'b0;
`endif
    end else begin
      r_core_start <= 1'b0;
      r_tx_start   <= 1'b0;
      r_frame_err  <= 1'b0;
      if (rx_rdy) r_idle_cnt <= '0;

      case (r_state)
        S_IDLE: begin
          if (rx_rdy) begin
            // First slice goes to the RAM port straight away, so UNPACK
            // lasts exactly SLICES cycles.
            r_shift     <= rx_data >> PIX_BITS;
            r_ram_wdata <= rx_data[PIX_BITS-1:0];
            r_ram_we    <= 1'b1;
            r_ram_addr  <= '0;
            r_slice     <= '0;
            r_byte_cnt  <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_UNPACK;
`ifdef FRAME_CHECKSUM_EN
            r_sum       <= rx_data;
            r_cs_err    <= 1'b0;
`endif
          end
        end

        S_RX_WAIT: begin
          if (rx_rdy) begin
`ifdef FRAME_CHECKSUM_EN
            if (r_byte_cnt == CNT_W'(FRAME_BYTES)) begin
              r_byte_cnt <= r_byte_cnt + CNT_W'(1);
              if (rx_data == r_sum) begin
                r_core_start <= 1'b1;
                r_state      <= S_CORE;
              end else begin
                r_frame_err <= 1'b1;
                r_cs_err    <= 1'b1;
                r_state     <= S_TX;
              end
            end else
`endif
            begin
              r_shift     <= rx_data >> PIX_BITS;
              r_ram_wdata <= rx_data[PIX_BITS-1:0];
              r_ram_we    <= 1'b1;
              r_ram_addr  <= r_ram_addr + ADDR_W'(1);
              r_slice     <= '0;
              r_state     <= S_UNPACK;
`ifdef FRAME_CHECKSUM_EN
              r_sum       <= r_sum + rx_data;
`endif
            end
          end else if (r_idle_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            r_idle_cnt  <= '0;
            r_frame_err <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_idle_cnt <= r_idle_cnt + TMO_W'(1);
          end
        end

        S_UNPACK: begin
          if (rx_rdy) begin
            // Overrun: the previous byte is still being written out.
            r_ram_we    <= 1'b0;
            r_frame_err <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else if (r_slice == SLICE_W'(SLICES - 1)) begin
            r_ram_we   <= 1'b0;
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            if (r_byte_cnt == CNT_W'(FRAME_BYTES - 1)) begin
`ifdef FRAME_CHECKSUM_EN
              r_state      <= S_RX_WAIT;
`else
              r_core_start <= 1'b1;
              r_state      <= S_CORE;
`endif
            end else begin
              r_state <= S_RX_WAIT;
            end
          end else begin
            r_ram_addr  <= r_ram_addr + ADDR_W'(1);
            r_ram_wdata <= r_shift[PIX_BITS-1:0];
            r_shift     <= r_shift >> PIX_BITS;
            r_slice     <= r_slice + SLICE_W'(1);
          end
        end

        S_CORE: begin
          if (core_done) begin
            r_result <= core_result;
            r_state  <= S_TX;
          end
        end

        S_TX: begin
          if (tx_rdy) begin
            r_tx_start <= 1'b1;
`ifdef FRAME_CHECKSUM_EN
            r_tx_data  <= r_cs_err ? 8'hEE : 8'(r_result);
`else
            r_tx_data  <= 8'(r_result);
`endif
            r_tx_first <= 1'b1;
            r_state    <= S_TX_WAIT;
          end
        end

        S_TX_WAIT: begin
          if (r_tx_first) begin
            r_tx_first <= 1'b0;
          end else if (tx_rdy) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_ram_we <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign core_start = r_core_start;
  assign tx_start   = r_tx_start;
  assign tx_data    = r_tx_data;
  assign busy       = r_busy;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_frame_loader
//
// Three frame_loader instances share one set of stimulus signals; `sel`
// routes rx_rdy/core_done to one instance and muxes its outputs to the
// monitor. Instance 0: defaults (98 bytes, 1 bit/word, short timeout).
// Instance 1: 4 bytes, 4 bits/word. Instance 2: 2 bytes, 8 bits/word.
// Expected RAM writes are computed from the byte values with plain
// arithmetic; a small transmitter model answers tx_start.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frame_loader;

  localparam int TMO = 256;
  typedef logic [7:0] byte_q_t [$];

  int N_OF  [3] = '{8, 2, 1};
  int PB_OF [3] = '{1, 4, 8};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = '0;
  logic       core_done = 1'b0;
  logic [3:0] core_result = '0;
  logic       tx_rdy = 1'b1;
  int         sel = 0;

  always #5 clk = ~clk;

  logic       a_we, b_we, c_we;
  logic [9:0] a_addr, b_addr, c_addr;
  logic [0:0] a_wd;
  logic [3:0] b_wd;
  logic [7:0] c_wd;
  logic       a_cs, b_cs, c_cs, a_ts, b_ts, c_ts;
  logic [7:0] a_td, b_td, c_td;
  logic       a_busy, b_busy, c_busy, a_fe, b_fe, c_fe;

  frame_loader #(.FRAME_BYTES(98), .PIX_BITS(1), .ADDR_W(10), .RESULT_W(4), .TIMEOUT_CYC(TMO)) u_a (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy && sel == 0), .rx_data(rx_data),
    .ram_we(a_we), .ram_addr(a_addr), .ram_wdata(a_wd), .core_start(a_cs),
    .core_done(core_done && sel == 0), .core_result(core_result), .tx_start(a_ts),
    .tx_data(a_td), .tx_rdy(tx_rdy), .busy(a_busy), .frame_err(a_fe));

  frame_loader #(.FRAME_BYTES(4), .PIX_BITS(4), .ADDR_W(10), .RESULT_W(4), .TIMEOUT_CYC(TMO)) u_b (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy && sel == 1), .rx_data(rx_data),
    .ram_we(b_we), .ram_addr(b_addr), .ram_wdata(b_wd), .core_start(b_cs),
    .core_done(core_done && sel == 1), .core_result(core_result), .tx_start(b_ts),
    .tx_data(b_td), .tx_rdy(tx_rdy), .busy(b_busy), .frame_err(b_fe));

  frame_loader #(.FRAME_BYTES(2), .PIX_BITS(8), .ADDR_W(10), .RESULT_W(4), .TIMEOUT_CYC(TMO)) u_c (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy && sel == 2), .rx_data(rx_data),
    .ram_we(c_we), .ram_addr(c_addr), .ram_wdata(c_wd), .core_start(c_cs),
    .core_done(core_done && sel == 2), .core_result(core_result), .tx_start(c_ts),
    .tx_data(c_td), .tx_rdy(tx_rdy), .busy(c_busy), .frame_err(c_fe));

  logic       m_we, m_cs, m_ts, m_busy, m_fe;
  logic [9:0] m_addr;
  logic [7:0] m_wd, m_td;

  always_comb begin
    m_we = a_we; m_addr = a_addr; m_wd = 8'(a_wd); m_cs = a_cs;
    m_ts = a_ts; m_td = a_td; m_busy = a_busy; m_fe = a_fe;
    if (sel == 1) begin
      m_we = b_we; m_addr = b_addr; m_wd = 8'(b_wd); m_cs = b_cs;
      m_ts = b_ts; m_td = b_td; m_busy = b_busy; m_fe = b_fe;
    end else if (sel == 2) begin
      m_we = c_we; m_addr = c_addr; m_wd = c_wd; m_cs = c_cs;
      m_ts = c_ts; m_td = c_td; m_busy = c_busy; m_fe = c_fe;
    end
  end

  // Monitor and transmitter model; sole writer of everything below.
  int         cyc = 0;
  int         n_cs = 0, n_ts = 0, n_fe = 0, cs_cyc = 0, fe_cyc = 0, tx_hold = 0;
  logic [7:0] last_tx = '0;
  int         wr_addr [$];
  int         wr_data [$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (m_we) begin
      wr_addr.push_back(int'(m_addr));
      wr_data.push_back(int'(m_wd));
    end
    if (m_cs) begin n_cs++; cs_cyc = cyc; end
    if (m_fe) begin n_fe++; fe_cyc = cyc; end
    if (m_ts) begin
      n_ts++; last_tx = m_td; tx_rdy = 1'b0; tx_hold = 4;
    end else if (tx_hold > 0) begin
      tx_hold--;
      if (tx_hold == 0) tx_rdy = 1'b1;
    end
  end

  int n_checks = 0, n_fail = 0;
  int last_rx_cyc = 0;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_rdy = 1'b1; rx_data = b; last_rx_cyc = cyc;
    @(negedge clk); rx_rdy = 1'b0;
  endtask

  // Payload with safe spacing; with the checksum feature, a trailing sum byte
  // (cs_byte < 0 means the correct sum).
  task automatic send_payload(input byte_q_t bytes, input int cs_byte);
    logic [7:0] sum = '0;
    foreach (bytes[j]) begin
      send_byte(bytes[j]);
      sum += bytes[j];
      if (j != bytes.size() - 1) idle(N_OF[sel] + $urandom_range(0, 3));
    end
`ifdef FRAME_CHECKSUM_EN
    idle(N_OF[sel] + 1);
    send_byte(cs_byte < 0 ? sum : cs_byte[7:0]);
`else
    if (cs_byte > 255) sum = '0;
`endif
  endtask

  task automatic run_frame(input string name, input byte_q_t bytes, input logic [3:0] res,
                           input int cs_byte, input bit poke_rx);
    int n = N_OF[sel];
    int pb = PB_OF[sel];
    int w0 = wr_addr.size();
    int cs0 = n_cs, ts0 = n_ts, fe0 = n_fe;
    int t, bad;
    bit ok = 1'b1;
    logic [7:0] sum = '0;
    logic [7:0] exp_tx;
    foreach (bytes[j]) sum += bytes[j];
`ifdef FRAME_CHECKSUM_EN
    ok = (cs_byte < 0) || (cs_byte[7:0] == sum);
`endif
    send_payload(bytes, cs_byte);

    t = 0;
    while (n_cs == cs0 && t < 80) begin @(negedge clk); t++; end
    if (ok) begin
      n_checks++;
      if (n_cs !== cs0 + 1) begin
        n_fail++; $display("FAIL %s core_start: count %0d, required %0d", name, n_cs - cs0, 1);
      end
`ifndef FRAME_CHECKSUM_EN
      n_checks++;
      if (cs_cyc - last_rx_cyc !== n + 1) begin
        n_fail++; $display("FAIL %s latency: %0d cycles, required %0d", name, cs_cyc - last_rx_cyc, n + 1);
      end
`endif
      if (poke_rx) send_byte(8'hFF);
      idle($urandom_range(1, 4));
      @(negedge clk); core_done = 1'b1; core_result = res;
      @(negedge clk); core_done = 1'b0;
      exp_tx = {4'h0, res};
    end else begin
      n_checks++;
      if (n_cs !== cs0) begin
        n_fail++; $display("FAIL %s no core_start: count %0d, required 0", name, n_cs - cs0);
      end
      exp_tx = 8'hEE;
    end

    t = 0;
    while (n_ts == ts0 && t < 60) begin @(negedge clk); t++; end
    n_checks++;
    if (n_ts !== ts0 + 1 || last_tx !== exp_tx) begin
      n_fail++; $display("FAIL %s tx: %0d starts data 0x%02h, required 1 start data 0x%02h",
                         name, n_ts - ts0, last_tx, exp_tx);
    end
    t = 0;
    while (m_busy && t < 60) begin @(negedge clk); t++; end
    n_checks++;
    if (m_busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy: %b, required 0", name, m_busy);
    end
    n_checks++;
    if (n_fe - fe0 !== (ok ? 0 : 1)) begin
      n_fail++; $display("FAIL %s frame_err: %0d pulses, required %0d", name, n_fe - fe0, ok ? 0 : 1);
    end

    n_checks++;
    if (wr_addr.size() - w0 !== bytes.size() * n) begin
      n_fail++; $display("FAIL %s write count: %0d, required %0d", name, wr_addr.size() - w0, bytes.size() * n);
    end
    n_checks++;
    bad = 0;
    for (int j = 0; j < bytes.size(); j++) begin
      for (int i = 0; i < n; i++) begin
        int k = w0 + j * n + i;
        int ea = j * n + i;
        int ed = (int'(bytes[j]) >> (i * pb)) & ((1 << pb) - 1);
        if (bad == 0 && (k >= wr_addr.size() || wr_addr[k] !== ea || wr_data[k] !== ed)) begin
          bad = 1;
          if (k < wr_addr.size())
            $display("FAIL %s write %0d: addr %0d data %0d, required addr %0d data %0d",
                     name, ea, wr_addr[k], wr_data[k], ea, ed);
          else
            $display("FAIL %s write %0d: missing, required addr %0d data %0d", name, ea, ea, ed);
        end
      end
    end
    if (bad != 0) n_fail++;
  endtask

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({a_we, a_addr, a_wd, a_cs, a_ts, a_td, a_busy, a_fe} !== 24'h0) begin
      n_fail++; $display("FAIL reset inst0: outputs 0x%06h, required 0", {a_we, a_addr, a_wd, a_cs, a_ts, a_td, a_busy, a_fe});
    end
    n_checks++;
    if ({b_we, b_addr, b_wd, b_cs, b_ts, b_td, b_busy, b_fe} !== 27'h0) begin
      n_fail++; $display("FAIL reset inst1: outputs 0x%07h, required 0", {b_we, b_addr, b_wd, b_cs, b_ts, b_td, b_busy, b_fe});
    end
    n_checks++;
    if ({c_we, c_addr, c_wd, c_cs, c_ts, c_td, c_busy, c_fe} !== 31'h0) begin
      n_fail++; $display("FAIL reset inst2: outputs 0x%08h, required 0", {c_we, c_addr, c_wd, c_cs, c_ts, c_td, c_busy, c_fe});
    end
    @(negedge clk); rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_default_frame;
    byte_q_t q;
    sel = 0;
    for (int i = 0; i < 98; i++) q.push_back(8'hA5);
    run_frame("a5_frame", q, 4'd7, -1, 1'b0);
    run_frame("rand_frame0", rand_bytes(98), 4'($urandom_range(0, 15)), -1, 1'b0);
  endtask

  task automatic test_pix4;
    byte_q_t q = '{8'h21, 8'h43, 8'h65, 8'h87};
    int w0;
    int bad = 0;
    sel = 1;
    w0 = wr_addr.size();
    run_frame("pix4_frame", q, 4'd3, -1, 1'b0);
    n_checks++;
    for (int i = 0; i < 8; i++)
      if (w0 + i >= wr_data.size() || wr_data[w0 + i] !== i + 1) bad = 1;
    if (bad != 0) begin
      n_fail++; $display("FAIL pix4 pattern: words differ, required 1..8 at addr 0..7");
    end
    for (int r = 0; r < 3; r++)
      run_frame("pix4_rand", rand_bytes(4), 4'($urandom_range(0, 15)), -1, 1'b0);
  endtask

  task automatic test_timeout;
    int fe0, t;
    sel = 0;
    fe0 = n_fe;
    for (int i = 0; i < 10; i++) begin
      send_byte(8'($urandom_range(0, 255)));
      idle(N_OF[0] + 1);
    end
    t = 0;
    while (n_fe == fe0 && t < TMO + 60) begin @(negedge clk); t++; end
    n_checks++;
    if (n_fe !== fe0 + 1 || fe_cyc - last_rx_cyc < TMO || fe_cyc - last_rx_cyc > TMO + N_OF[0] + 2) begin
      n_fail++; $display("FAIL timeout: %0d pulses at %0d cycles after last byte, required 1 at %0d..%0d",
                         n_fe - fe0, fe_cyc - last_rx_cyc, TMO, TMO + N_OF[0] + 2);
    end
    idle(1);
    n_checks++;
    if (m_busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout busy: %b, required 0", m_busy);
    end
    idle(2 * TMO);
    n_checks++;
    if (n_fe !== fe0 + 1) begin
      n_fail++; $display("FAIL idle no timeout: %0d pulses, required 1", n_fe - fe0);
    end
    run_frame("after_timeout", rand_bytes(98), 4'($urandom_range(0, 15)), -1, 1'b0);
  endtask

  task automatic test_overrun;
    int fe0 = n_fe, cs0 = n_cs;
    sel = 0;
    send_byte(8'h5A);
    idle(1);
    send_byte(8'hC3);
    idle(20);
    n_checks++;
    if (n_fe !== fe0 + 1 || m_busy !== 1'b0 || n_cs !== cs0) begin
      n_fail++; $display("FAIL overrun: err %0d busy %b core_start %0d, required err 1 busy 0 core_start 0",
                         n_fe - fe0, m_busy, n_cs - cs0);
    end
  endtask

  task automatic test_ignored_inputs;
    int cs0, ts0;
    sel = 1;
    cs0 = n_cs; ts0 = n_ts;
    @(negedge clk); core_done = 1'b1; core_result = 4'hB;
    @(negedge clk); core_done = 1'b0;
    idle(10);
    n_checks++;
    if (n_cs !== cs0 || n_ts !== ts0 || m_busy !== 1'b0) begin
      n_fail++; $display("FAIL stray core_done: core_start %0d tx %0d busy %b, required 0 0 0",
                         n_cs - cs0, n_ts - ts0, m_busy);
    end
    run_frame("rx_in_core", rand_bytes(4), 4'($urandom_range(0, 15)), -1, 1'b1);
  endtask

  task automatic test_reset_mid;
    int cs0, ts0, t;
    sel = 1;
    cs0 = n_cs; ts0 = n_ts;
    send_payload(rand_bytes(4), -1);
    t = 0;
    while (n_cs == cs0 && t < 80) begin @(negedge clk); t++; end
    idle(1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    n_checks++;
    if ({b_we, b_addr, b_wd, b_cs, b_ts, b_td, b_busy, b_fe} !== 27'h0 || n_cs !== cs0 + 1) begin
      n_fail++; $display("FAIL reset in core: outputs 0x%07h core_start %0d, required 0 and 1",
                         {b_we, b_addr, b_wd, b_cs, b_ts, b_td, b_busy, b_fe}, n_cs - cs0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); core_done = 1'b1; core_result = 4'h9;
    @(negedge clk); core_done = 1'b0;
    idle(20);
    n_checks++;
    if (n_ts !== ts0 || m_busy !== 1'b0) begin
      n_fail++; $display("FAIL core_done after reset: tx %0d busy %b, required 0 0", n_ts - ts0, m_busy);
    end
    run_frame("pix4_after_reset", rand_bytes(4), 4'($urandom_range(0, 15)), -1, 1'b0);

    sel = 0;
    for (int i = 0; i < 5; i++) begin send_byte(8'($urandom_range(0, 255))); idle(9); end
    send_byte(8'hFF);
    idle(3);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    idle(2);
    run_frame("frame_after_reset", rand_bytes(98), 4'($urandom_range(0, 15)), -1, 1'b0);
  endtask

  task automatic test_short_frame;
    byte_q_t q = '{8'h10, 8'h20};
    sel = 2;
`ifdef FRAME_CHECKSUM_EN
    run_frame("cs_bad", q, 4'd5, 8'h31, 1'b0);
    run_frame("cs_good", q, 4'd5, 8'h30, 1'b0);
`endif
    run_frame("short_frame", q, 4'd5, -1, 1'b0);
    run_frame("short_rand", rand_bytes(2), 4'($urandom_range(0, 15)), -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_pix4();
    test_timeout();
    test_overrun();
    test_ignored_inputs();
    test_reset_mid();
    test_short_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_loader.md
FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 Parameter FRAME_BYTES, default 98, the number of payload bytes per frame.
REQ-002 Parameter PIX_BITS, default 1, the bits per RAM word; the only legal values are 1, 2, 4 and 8.
REQ-003 Parameter ADDR_W, default 10, the RAM address width; FRAME_BYTES*8/PIX_BITS SHALL be <= 2**ADDR_W.
REQ-004 Parameter RESULT_W, default 4, the width of the core result (<= 8).
REQ-005 Parameter TIMEOUT_CYC, default 50000, the clk cycles of inter-byte silence that abort a partial frame.
REQ-006 clk  in  1  system clock, rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 rx_rdy  in  1  one-cycle pulse; rx_data is valid.
REQ-009 rx_data  in  8  received UART byte.
REQ-010 ram_we  out  1  RAM write enable.
REQ-011 ram_addr  out  ADDR_W  RAM write address.
REQ-012 ram_wdata  out  PIX_BITS  RAM write data.
REQ-013 core_start  out  1  one-cycle pulse that launches inference.
REQ-014 core_done  in  1  one-cycle pulse; core_result is valid.
REQ-015 core_result  in  RESULT_W  inference result.
REQ-016 tx_start  out  1  one-cycle pulse to the UART transmitter.
REQ-017 tx_data  out  8  byte to transmit.
REQ-018 tx_rdy  in  1  transmitter idle; it drops the cycle after tx_start.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 frame_err  out  1  one-cycle pulse on a timeout, overrun or checksum failure.

Function
REQ-021 The FSM SHALL have the states IDLE, RX_WAIT, UNPACK, CORE, TX and TX_WAIT.
REQ-022 IDLE: on rx_rdy, latch rx_data into the shift register, clear the byte count, set the address to 0, go to UNPACK.
REQ-023 UNPACK: for 8/PIX_BITS consecutive cycles, ram_we=1, ram_wdata=shift[PIX_BITS-1:0], address then increments, shift right by PIX_BITS (LSB-first).
REQ-024 After the last slice of a byte, the byte count increments; the FSM goes to CORE when count==FRAME_BYTES, otherwise to RX_WAIT.
REQ-025 RX_WAIT: on rx_rdy, latch the byte and go to UNPACK; the address continues without reset.
REQ-026 CORE entry: core_start pulses for exactly 1 cycle; the FSM waits for core_done, latches core_result, then goes to TX.
REQ-027 TX: when tx_rdy=1, tx_start pulses for 1 cycle with tx_data={zero-pad, result}; the FSM then goes to TX_WAIT.
REQ-028 TX_WAIT: the minimum stay is 1 cycle; the FSM exits to IDLE when tx_rdy=1.
REQ-029 Latency from the final payload byte's rx_rdy to core_start SHALL be 8/PIX_BITS+1 cycles.
REQ-030 An rx_rdy during UNPACK (overrun) SHALL pulse frame_err, drop the frame and return to IDLE.
REQ-031 rx_rdy in CORE, TX or TX_WAIT SHALL be ignored, with no error.
REQ-032 Timeout: the idle counter clears on every rx_rdy and counts only in RX_WAIT.
REQ-033 When the idle counter reaches TIMEOUT_CYC-1, frame_err SHALL pulse and the FSM goes to IDLE; it SHALL NOT time out in IDLE.
REQ-034 A core_done outside CORE SHALL be ignored.
REQ-035 The byte count SHALL NOT wrap; its maximum is FRAME_BYTES (+1 with checksum).
REQ-036 The address SHALL never exceed FRAME_BYTES*8/PIX_BITS-1 during a frame.

Reset
REQ-037 On rst_n low: state=IDLE and counters=0.
REQ-038 On rst_n low: ram_we, core_start, tx_start, frame_err and busy = 0.
REQ-039 On rst_n low: ram_addr, ram_wdata, tx_data and the result register = 0.
REQ-040 A reset mid-frame or mid-transmit SHALL abandon all progress; the next frame SHALL start at address 0.

Configuration
REQ-041 With FRAME_CHECKSUM_EN defined, the frame SHALL be FRAME_BYTES payload bytes plus 1 checksum byte.
REQ-042 The checksum byte SHALL be the modulo-256 sum of the payload and SHALL NOT be written to RAM.
REQ-043 On a checksum match, the FSM SHALL go to CORE.
REQ-044 On a mismatch: frame_err pulses, there is no core_start, the block transmits 0xEE via TX/TX_WAIT, then returns to IDLE.
REQ-045 Without FRAME_CHECKSUM_EN, there SHALL be no checksum logic, and the frame ends after FRAME_BYTES.

Verification
REQ-046 Defaults, 98 bytes of 0xA5 -> 784 writes, addr 0..783, wdata pattern 1,0,1,0,0,1,0,1 per byte; core_result=7 -> tx_data=0x07.
REQ-047 PIX_BITS=4, FRAME_BYTES=4, bytes 0x21,0x43,0x65,0x87 -> wdata 1..8 at addr 0..7, core_start 3 cycles after the last rx_rdy.
REQ-048 Send 10 bytes, then silence for TIMEOUT_CYC -> frame_err pulse, busy=0; the next 98-byte frame writes from addr 0.
REQ-049 rx_rdy pulses 3 cycles apart, defaults -> frame_err at the 2nd pulse, return to IDLE, no core_start.
REQ-050 FRAME_CHECKSUM_EN, FRAME_BYTES=2, bytes 0x10,0x20,0x31 -> tx_data=0xEE, no core_start; with checksum 0x30 -> core_start.
REQ-051 Assert rst_n low in CORE -> all outputs 0, and core_done afterwards is ignored.
